// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the UART TX front-end and the serializer.
// Registered read with one-cycle latency, flags decoded from the occupancy count.
module uart_tx_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     baud_clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             full_c, empty_c;
  logic             wr_acc, rd_acc;

  assign full_c  = (count_q == DEPTH_C);
  assign empty_c = (count_q == '0);

  // A write into a full FIFO is still taken when a read frees the oldest slot
  // in the same cycle; that slot is exactly where wr_ptr points.
  assign wr_acc = wr_en & (~full_c | rd_en);
  assign rd_acc = rd_en & ~empty_c;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_acc;
    overflow_d  = wr_en & full_c & ~rd_en;
    underflow_d = rd_en & empty_c;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge baud_clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign count       = count_q;
  assign full        = full_c;
  assign empty       = empty_c;
  assign almost_full = (count_q >= AF_C);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO's observable behaviour.
module tb_uart_tx_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic             baud_clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid, full, empty, almost_full, overflow, underflow;
  logic [4:0]       count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] exp_rd_data = '0;
  logic             exp_rd_valid = 1'b0;
  logic             exp_ovf = 1'b0;
  logic             exp_udf = 1'b0;

  uart_tx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rs);
    int sz;
    bit m_full, m_empty;
    wr_en = w; wr_data = d; rd_en = r; rst = rs;
    @(posedge baud_clk);
    sz = q.size();
    m_full  = (sz == DEPTH);
    m_empty = (sz == 0);
    if (rs) begin
      q.delete();
      exp_rd_data  = '0;
      exp_rd_valid = 1'b0;
      exp_ovf      = 1'b0;
      exp_udf      = 1'b0;
    end else begin
      exp_ovf      = w & m_full & ~r;
      exp_udf      = r & m_empty;
      exp_rd_valid = r & ~m_empty;
      if (r && !m_empty) exp_rd_data = q.pop_front();
      if (w && (!m_full || r)) q.push_back(d);
    end
    #1;
    chk("count",       32'(count),       32'(q.size()));
    chk("empty",       32'(empty),       32'(q.size() == 0));
    chk("full",        32'(full),        32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("rd_valid",    32'(rd_valid),    32'(exp_rd_valid));
    chk("rd_data",     32'(rd_data),     32'(exp_rd_data));
    chk("overflow",    32'(overflow),    32'(exp_ovf));
    chk("underflow",   32'(underflow),   32'(exp_udf));
    $display("t=%0t rst=%0b wr=%0b d=%02h rd=%0b -> cnt=%0d rv=%0b rdat=%02h ovf=%0b udf=%0b",
             $time, rs, w, d, r, count, rd_valid, rd_data, overflow, underflow);
  endtask

  initial begin
    // Reset then idle
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_count", 32'(count), 32'd0);

    // Three bytes through
    step(1'b1, 8'h41, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk("tp2_rd0", 32'(rd_data), 32'h41);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk("tp2_rd1", 32'(rd_data), 32'h42);
    step(1'b0, 8'h00, 1'b1, 1'b0); chk("tp2_rd2", 32'(rd_data), 32'h43);
    chk("tp2_empty", 32'(empty), 32'd1);

    // Fill to full, overflow, drain
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) chk("tp3_af_below", 32'(almost_full), 32'd0);
      if (i == 11) chk("tp3_af_at",    32'(almost_full), 32'd1);
    end
    chk("tp3_full", 32'(full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("tp3_ovf", 32'(overflow), 32'd1);
    chk("tp3_cnt", 32'(count), 32'd16);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tp3_ovf_drop", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("tp3_drain", 32'(rd_data), 32'(i));
    end

    // Read+write while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("tp4_rd", 32'(rd_data), 32'h00);
    chk("tp4_cnt", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tp4_last", 32'(rd_data), 32'hA5);

    // Read+write while empty
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("tp5_udf", 32'(underflow), 32'd1);
    chk("tp5_rv",  32'(rd_valid), 32'd0);
    chk("tp5_cnt", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tp5_rd", 32'(rd_data), 32'h5A);

    // Mid-stream reset, then wrap-around traffic
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("tp6_cnt",   32'(count), 32'd0);
    chk("tp6_empty", 32'(empty), 32'd1);
    chk("tp6_rv",    32'(rd_valid), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'hC0 + i), (i > 2), 1'b0);
      if (i > 2) chk("tp6_order", 32'(rd_data), 32'(8'hC0 + i - 3));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic w, r, rs;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 45);
      rs = ($urandom_range(0, 299) == 0);
      step(w, 8'($urandom), r, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Synchronous byte FIFO between the UART TX front-end (the stage that captures new host bytes) and the TX serializer.
- Accepts a byte whenever the front-end raises its new-data strobe. Returns full to throttle the front-end, which holds off capture while full is high.
- Supplies bytes to the serializer on a registered read. Single clock domain: baud_clk.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.

Ports:
- baud_clk  in  1  system/baud clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe from front-end new-data output.
- wr_data  in  WIDTH  byte to store.
- rd_en  in  1  read request from serializer.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  high one cycle after an accepted read; rd_data valid in that cycle.
- full  out  1  count == DEPTH; drives front-end FIFO-full input.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst high at a rising edge) forces the following, regardless of wr_en/rd_en that cycle:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Flags after reset: empty = 1, full = 0, almost_full = 0.
  - Storage array contents are not reset.
  - Reset mid-operation discards all stored bytes, and any read that was accepted in the reset cycle is dropped.
- Accept rules, evaluated on the pre-edge state:
  - wr_acc = wr_en & (~full | rd_en).
  - rd_acc = rd_en & ~empty.
- Accepted write: mem[wr_ptr] <= wr_data; wr_ptr increments modulo DEPTH.
- Accepted read: rd_data <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_valid <= 1 the next cycle, otherwise 0.
  - Read latency is 1 cycle.
  - rd_data holds its last value when no read is accepted.
- Count update: count + wr_acc - rd_acc. Simultaneous accepted read and write leaves count unchanged.
- Simultaneous rd_en & wr_en when full: both accepted. The read returns the oldest entry; the write lands in the slot being freed; count stays DEPTH.
- Simultaneous rd_en & wr_en when empty: write accepted, read rejected (underflow pulses); count becomes 1. There is no write-to-read bypass.
- Rejected write: wr_en & full & ~rd_en. Data is dropped, pointers and count are unchanged, and overflow = 1 for the next cycle.
- Rejected read: rd_en & empty. Pointers are unchanged, rd_valid = 0, and underflow = 1 for the next cycle.
- Flags full, empty and almost_full are decoded combinationally from the registered count. They change in the same cycle count changes, with no extra latency.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally.
- Ordering is strict FIFO under any interleaving.
- Since the front-end strobes once per new byte, consecutive wr_en cycles are legal and each is treated as a separate write.

Test Plan:
- Reset, then idle → empty = 1, full = 0, count = 0, rd_valid = 0, overflow = 0, underflow = 0.
- Write 0x41, 0x42, 0x43 on consecutive cycles, then rd_en for 3 cycles → rd_data = 0x41, 0x42, 0x43, each with rd_valid, one cycle after the corresponding rd_en; count ends at 0, empty = 1.
- Write 16 bytes 0x00..0x0F → full = 1 after the 16th write, almost_full = 1 from the 12th write. A 17th write of 0xFF → overflow pulses one cycle, count stays 16; draining returns 0x00..0x0F with no 0xFF.
- When full, rd_en & wr_en with wr_data = 0xA5 for one cycle → rd_data = 0x00, count = 16; after draining, the last byte read = 0xA5.
- When empty, rd_en & wr_en with wr_data = 0x5A → underflow pulses, rd_valid = 0, count = 1; the next rd_en returns 0x5A.
- Fill with 10 bytes, read 2, assert rst for one cycle mid-stream → count = 0, empty = 1, rd_valid = 0 the next cycle. Then write/read 40 bytes to exercise pointer wrap; data order is preserved.
